// File: rtl/rr_arbiter_ctl.sv
// rr_arbiter_ctl: round-robin arbiter with one grant at a time, a per-grant hold limit,
// and a single-cycle timeout pulse when the hold limit forces the release.
module rr_arbiter_ctl #(
  parameter int N        = 6,
  parameter int HOLD_MAX = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy,
  output logic                 timeout
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic [7:0]    cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW:0]   sum, wrapped;
  logic          owner_req, at_limit, rel;
  assign owner_req = req[idx_q];
  assign at_limit  = cnt_q == 8'(HOLD_MAX - 1);
  assign rel       = (state_q == BUSY) && (done || !owner_req || at_limit);
  assign timeout   = (state_q == BUSY) && at_limit && !done && owner_req;
  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign busy      = state_q == BUSY;
  // Scan offsets from farthest to nearest so the first set bit at or after ptr wins.
  always_comb begin
    win     = '0;
    sum     = '0;
    wrapped = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum     = {1'b0, ptr_q} + (IW+1)'(k);
      wrapped = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
      if (req[wrapped[IW-1:0]]) win = wrapped[IW-1:0];
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = BUSY;
        idx_d   = win;
        gnt_d   = N'(1) << win;
        cnt_d   = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
      ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_ctl.sv
// tb_rr_arbiter_ctl: directed self-checking bench for rr_arbiter_ctl (N=6, HOLD_MAX=5).
module tb_rr_arbiter_ctl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] req = '0;
  logic       done = 1'b0;
  logic [5:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy, timeout;
  int         n_checks = 0;
  int         n_fail = 0;
  rr_arbiter_ctl #(.N(6), .HOLD_MAX(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #3;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 6'b111111;
    done  = 1'b0;
    step();
    step();
    n_checks++; if (gnt !== 6'b0) begin n_fail++; $display("FAIL reset_gnt got %b want %b", gnt, 6'b0); end
    n_checks++; if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", gnt_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    rst_n = 1'b1;
    step();
    n_checks++; if (gnt !== 6'b000001) begin n_fail++; $display("FAIL first_gnt got %b want %b", gnt, 6'b000001); end
    n_checks++; if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL first_idx got %0d want 0", gnt_idx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy got %b want 1", busy); end
    req = '0;
  endtask
  task automatic test_rotation();
    logic [2:0] e;
    logic [5:0] one;
    do_reset();
    req = 6'b111111;
    step();
    for (int i = 0; i < 7; i++) begin
      e   = 3'(i % 6);
      one = 6'd1 << e;
      n_checks++; if (gnt_idx !== e) begin n_fail++; $display("FAIL rot_idx[%0d] got %0d want %0d", i, gnt_idx, e); end
      n_checks++; if (gnt !== one) begin n_fail++; $display("FAIL rot_gnt[%0d] got %b want %b", i, gnt, one); end
      done = 1'b1;
      #1;
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rot_timeout[%0d] got %b want 0", i, timeout); end
      step();
      done = 1'b0;
      n_checks++; if (gnt !== 6'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rot_gap[%0d] got gnt=%b busy=%b want 0/0", i, gnt, busy); end
      if (i == 6) req = '0;
      step();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rot_end_busy got %b want 0", busy); end
  endtask
  task automatic test_timeout();
    do_reset();
    req = 6'b001000;
    step();
    for (int c = 1; c <= 5; c++) begin
      n_checks++; if (gnt !== 6'b001000) begin n_fail++; $display("FAIL to_gnt[%0d] got %b want %b", c, gnt, 6'b001000); end
      n_checks++; if (timeout !== (c == 5)) begin n_fail++; $display("FAIL to_pulse[%0d] got %b want %b", c, timeout, c == 5); end
      if (c < 5) step();
    end
    step();
    n_checks++; if (gnt !== 6'b0 || busy !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_gap got gnt=%b busy=%b to=%b want 0/0/0", gnt, busy, timeout); end
    n_checks++; if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL to_gap_idx got %0d want 0", gnt_idx); end
    step();
    n_checks++; if (gnt !== 6'b001000 || gnt_idx !== 3'd3) begin n_fail++; $display("FAIL to_regrant got gnt=%b idx=%0d want 001000/3", gnt, gnt_idx); end
    req = '0;
    step();
    step();
  endtask
  task automatic test_drop_and_done();
    do_reset();
    req = 6'b000100;
    step();
    n_checks++; if (gnt_idx !== 3'd2) begin n_fail++; $display("FAIL drop_owner got %0d want 2", gnt_idx); end
    step();
    req = 6'b000000;
    #1;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL drop_timeout got %b want 0", timeout); end
    step();
    n_checks++; if (gnt !== 6'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_release got gnt=%b busy=%b want 0/0", gnt, busy); end
    req = 6'b001100;
    step();
    n_checks++; if (gnt_idx !== 3'd3) begin n_fail++; $display("FAIL drop_ptr got %0d want 3", gnt_idx); end
    step();
    step();
    step();
    step();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL limit_pulse got %b want 1", timeout); end
    done = 1'b1;
    #1;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL done_at_limit got %b want 0", timeout); end
    n_checks++; if (gnt !== 6'b001000) begin n_fail++; $display("FAIL done_at_limit_gnt got %b want %b", gnt, 6'b001000); end
    step();
    done = 1'b0;
    req  = '0;
    n_checks++; if (gnt !== 6'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL done_release got gnt=%b to=%b want 0/0", gnt, timeout); end
  endtask
  task automatic test_idle_done();
    do_reset();
    done = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || gnt !== 6'b0) begin n_fail++; $display("FAIL idle_done got busy=%b gnt=%b want 0/0", busy, gnt); end
    req = 6'b000010;
    step();
    n_checks++; if (gnt !== 6'b000010 || gnt_idx !== 3'd1) begin n_fail++; $display("FAIL idle_done_grant got gnt=%b idx=%0d want 000010/1", gnt, gnt_idx); end
    step();
    done = 1'b0;
    req  = '0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_done_release got %b want 0", busy); end
  endtask
  task automatic test_async_reset();
    do_reset();
    req = 6'b010000;
    step();
    n_checks++; if (gnt !== 6'b010000) begin n_fail++; $display("FAIL ar_pre got %b want %b", gnt, 6'b010000); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 6'b0 || busy !== 1'b0 || gnt_idx !== 3'd0) begin n_fail++; $display("FAIL ar_drop got gnt=%b busy=%b idx=%0d want 0/0/0", gnt, busy, gnt_idx); end
    req = 6'b100000;
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (gnt_idx !== 3'd5 || gnt !== 6'b100000) begin n_fail++; $display("FAIL ar_regrant got idx=%0d gnt=%b want 5/100000", gnt_idx, gnt); end
    rst_n = 1'b0;
    req   = 6'b110000;
    #1;
    rst_n = 1'b1;
    step();
    n_checks++; if (gnt_idx !== 3'd4) begin n_fail++; $display("FAIL ar_ptr0 got %0d want 4", gnt_idx); end
    req = '0;
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_drop_and_done();
    test_idle_done();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
